unstriping_ctrl: RTL and testbench

UNSTRIPING_CTRL -- requirements
Module: unstriping_ctrl

---
 rtl/unstriping_pkg.sv | 14 +
 rtl/lane_fifo.sv | 63 ++++++
 rtl/unstriping_ctrl.sv | 136 +++++++++++++
 tb/tb_unstriping_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/unstriping_pkg.sv
// Shared types and constants for the two-lane unstriping controller.
package unstriping_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 8;

    typedef enum logic [1:0] {
        EXP0   = 2'd0,
        EXP1   = 2'd1,
        RESYNC = 2'd2
    } state_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane FIFO; a push into a full FIFO is accepted only if it pops on the same edge.
module lane_fifo
    import unstriping_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_2f) begin
        if (do_push && reset_L && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/unstriping_ctrl.sv
// Merges two striped lanes back into one stream, alternating lane 0 / lane 1,
// with a stall timeout that flushes both lanes and realigns on lane 0.
module unstriping_ctrl
    import unstriping_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [WORD_W-1:0] data_in0,
    input  logic              valid_in0,
    input  logic [WORD_W-1:0] data_in1,
    input  logic              valid_in1,
    input  logic              ready_out,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_out,
    output logic [15:0]       word_cnt,
    output logic              err_ovf,
    output logic              err_tmo,
    output logic [1:0]        state_out
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state;
    logic [7:0]        stall_cnt;

    logic [WORD_W-1:0] dout0, dout1;
    logic              empty0, empty1;
    logic              full0, full1;
    logic              push0, push1;
    logic              pop0, pop1;
    logic              flush;
    logic              ovf0, ovf1;

    logic              exp_lane;
    logic              cur_empty;
    logic              oth_empty;
    logic              timeout_hit;
    logic              pop_go;

    assign exp_lane    = (state == EXP1);
    assign cur_empty   = exp_lane ? empty1 : empty0;
    assign oth_empty   = exp_lane ? empty0 : empty1;
    assign timeout_hit = (state != RESYNC) && (stall_cnt == TMO);
    // A pending timeout wins over a pop that would otherwise happen on the same edge.
    assign pop_go      = (state != RESYNC) && !timeout_hit && !cur_empty && ready_out;
    assign pop0        = pop_go && !exp_lane;
    assign pop1        = pop_go && exp_lane;

    assign flush       = (state == RESYNC);
    assign push0       = valid_in0 && !flush;
    assign push1       = valid_in1 && !flush;
    assign ovf0        = push0 && full0 && !pop0;
    assign ovf1        = push1 && full1 && !pop1;

    assign state_out   = state;

    lane_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo0 (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .push    (push0),
        .pop     (pop0),
        .flush   (flush),
        .din     (data_in0),
        .dout    (dout0),
        .empty   (empty0),
        .full    (full0)
    );

    lane_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo1 (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .push    (push1),
        .pop     (pop1),
        .flush   (flush),
        .din     (data_in1),
        .dout    (dout1),
        .empty   (empty1),
        .full    (full1)
    );

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            state     <= EXP0;
            stall_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_out  <= 1'b0;
            word_cnt  <= '0;
            err_ovf   <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (ovf0 || ovf1) begin
                err_ovf <= 1'b1;
            end
            case (state)
                RESYNC: begin
                    state     <= EXP0;
                    stall_cnt <= '0;
                end
                default: begin
                    if (timeout_hit) begin
                        state     <= RESYNC;
                        stall_cnt <= '0;
                        err_tmo   <= 1'b1;
                    end else if (pop_go) begin
                        data_out  <= exp_lane ? dout1 : dout0;
                        lane_out  <= exp_lane;
                        valid_out <= 1'b1;
                        word_cnt  <= word_cnt + 16'd1;
                        state     <= exp_lane ? EXP0 : EXP1;
                        stall_cnt <= '0;
                    end else if (ready_out) begin
                        // Expected lane is empty here; back-pressure freezes the counter.
                        if (!oth_empty) begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end else begin
                            stall_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unstriping_ctrl.sv
// Directed, table-driven bench for unstriping_ctrl with hand-built corner sequences.
module tb_unstriping_ctrl;

    logic        clk_2f = 1'b0;
    logic        reset_L;
    logic [31:0] data_in0, data_in1;
    logic        valid_in0, valid_in1;
    logic        ready_out;
    logic [31:0] data_out;
    logic        valid_out;
    logic        lane_out;
    logic [15:0] word_cnt;
    logic        err_ovf, err_tmo;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_2f = ~clk_2f;

    unstriping_ctrl #(
        .DEPTH   (4),
        .TIMEOUT (8)
    ) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .data_in0  (data_in0),
        .valid_in0 (valid_in0),
        .data_in1  (data_in1),
        .valid_in1 (valid_in1),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .word_cnt  (word_cnt),
        .err_ovf   (err_ovf),
        .err_tmo   (err_tmo),
        .state_out (state_out)
    );

    typedef struct {
        logic        rst_n;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [15:0] ec;
        logic [1:0]  es;
        logic        eo;
        logic        et;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1, input logic rdy,
                                input logic ev, input logic [31:0] ed, input logic el,
                                input logic [15:0] ec, input logic [1:0] es,
                                input logic eo, input logic et);
        vec_t v;
        v.rst_n = r;  v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.es = es; v.eo = eo; v.et = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one vector before the edge, then sample 1 time unit after it.
    task automatic run(input vec_t v, input string tag);
        reset_L   = v.rst_n;
        valid_in0 = v.v0;
        data_in0  = v.d0;
        valid_in1 = v.v1;
        data_in1  = v.d1;
        ready_out = v.rdy;
        @(posedge clk_2f);
        #1;
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(v.ev));
        chk({tag, ".data_out"},  data_out,       v.ed);
        chk({tag, ".lane_out"},  32'(lane_out),  32'(v.el));
        chk({tag, ".word_cnt"},  32'(word_cnt),  32'(v.ec));
        chk({tag, ".state_out"}, 32'(state_out), 32'(v.es));
        chk({tag, ".err_ovf"},   32'(err_ovf),   32'(v.eo));
        chk({tag, ".err_tmo"},   32'(err_tmo),   32'(v.et));
    endtask

    vec_t tbl[26];

    initial begin
        reset_L   = 1'b0;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        data_in0  = '0;
        data_in1  = '0;
        ready_out = 1'b0;

        // Reset, alternating stream, then lane-0 overflow and drain.
        tbl[0]  = mk(0, 0, 0,      0, 0,      1,  0, 32'h00, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'hA0, 0, 0,      1,  0, 32'h00, 0,  0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0,      1, 32'hB0, 1,  1, 32'hA0, 0,  1, 1, 0, 0);
        tbl[3]  = mk(1, 1, 32'hA1, 0, 0,      1,  1, 32'hB0, 1,  2, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0,      1, 32'hB1, 1,  1, 32'hA1, 0,  3, 1, 0, 0);
        tbl[5]  = mk(1, 1, 32'hA2, 0, 0,      1,  1, 32'hB1, 1,  4, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0,      1, 32'hB2, 1,  1, 32'hA2, 0,  5, 1, 0, 0);
        tbl[7]  = mk(1, 1, 32'hA3, 0, 0,      1,  1, 32'hB2, 1,  6, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0,      1, 32'hB3, 1,  1, 32'hA3, 0,  7, 1, 0, 0);
        tbl[9]  = mk(1, 0, 0,      0, 0,      1,  1, 32'hB3, 1,  8, 0, 0, 0);
        tbl[10] = mk(1, 0, 0,      0, 0,      1,  0, 32'hB3, 1,  8, 0, 0, 0);
        tbl[11] = mk(1, 1, 32'hC0, 0, 0,      0,  0, 32'hB3, 1,  8, 0, 0, 0);
        tbl[12] = mk(1, 1, 32'hC1, 0, 0,      0,  0, 32'hB3, 1,  8, 0, 0, 0);
        tbl[13] = mk(1, 1, 32'hC2, 0, 0,      0,  0, 32'hB3, 1,  8, 0, 0, 0);
        tbl[14] = mk(1, 1, 32'hC3, 0, 0,      0,  0, 32'hB3, 1,  8, 0, 0, 0);
        tbl[15] = mk(1, 1, 32'hC4, 0, 0,      0,  0, 32'hB3, 1,  8, 0, 1, 0);
        tbl[16] = mk(1, 0, 0,      0, 0,      1,  1, 32'hC0, 0,  9, 1, 1, 0);
        tbl[17] = mk(1, 0, 0,      1, 32'hD0, 1,  0, 32'hC0, 0,  9, 1, 1, 0);
        tbl[18] = mk(1, 0, 0,      0, 0,      1,  1, 32'hD0, 1, 10, 0, 1, 0);
        tbl[19] = mk(1, 0, 0,      1, 32'hD1, 1,  1, 32'hC1, 0, 11, 1, 1, 0);
        tbl[20] = mk(1, 0, 0,      1, 32'hD2, 1,  1, 32'hD1, 1, 12, 0, 1, 0);
        tbl[21] = mk(1, 0, 0,      1, 32'hD3, 1,  1, 32'hC2, 0, 13, 1, 1, 0);
        tbl[22] = mk(1, 0, 0,      0, 0,      1,  1, 32'hD2, 1, 14, 0, 1, 0);
        tbl[23] = mk(1, 0, 0,      0, 0,      1,  1, 32'hC3, 0, 15, 1, 1, 0);
        tbl[24] = mk(1, 0, 0,      0, 0,      1,  1, 32'hD3, 1, 16, 0, 1, 0);
        tbl[25] = mk(1, 0, 0,      0, 0,      1,  0, 32'hD3, 1, 16, 0, 1, 0);

        for (int i = 0; i < 26; i++) begin
            run(tbl[i], $sformatf("tbl%0d", i));
        end

        // Back-pressure with words pending in both lanes, then release.
        run(mk(1, 1, 32'hE0, 1, 32'hE1, 0,  0, 32'hD3, 1, 16, 0, 1, 0), "bp_push");
        for (int i = 0; i < 10; i++) begin
            run(mk(1, 0, 0, 0, 0, 0,  0, 32'hD3, 1, 16, 0, 1, 0), $sformatf("bp_hold%0d", i));
        end
        run(mk(1, 0, 0, 0, 0, 1,  1, 32'hE0, 0, 17, 1, 1, 0), "bp_rel0");
        run(mk(1, 0, 0, 0, 0, 1,  1, 32'hE1, 1, 18, 0, 1, 0), "bp_rel1");
        run(mk(1, 0, 0, 0, 0, 1,  0, 32'hE1, 1, 18, 0, 1, 0), "bp_idle");

        // Stall counter frozen under back-pressure, then timeout and resync.
        run(mk(1, 0, 0, 1, 32'hF0, 0,  0, 32'hE1, 1, 18, 0, 1, 0), "tmo_push");
        for (int i = 0; i < 20; i++) begin
            run(mk(1, 0, 0, 0, 0, 0,  0, 32'hE1, 1, 18, 0, 1, 0), $sformatf("tmo_frz%0d", i));
        end
        for (int i = 1; i <= 8; i++) begin
            run(mk(1, 0, 0, 0, 0, 1,  0, 32'hE1, 1, 18, 0, 1, 0), $sformatf("tmo_cnt%0d", i));
        end
        run(mk(1, 0, 0,      0, 0,      1,  0, 32'hE1, 1, 18, 2, 1, 1), "tmo_enter");
        run(mk(1, 1, 32'h60, 1, 32'h61, 1,  0, 32'hE1, 1, 18, 0, 1, 1), "tmo_resync");
        run(mk(1, 0, 0,      0, 0,      1,  0, 32'hE1, 1, 18, 0, 1, 1), "tmo_after");
        run(mk(1, 1, 32'h70, 0, 0,      1,  0, 32'hE1, 1, 18, 0, 1, 1), "tmo_h0");
        run(mk(1, 0, 0,      1, 32'h71, 1,  1, 32'h70, 0, 19, 1, 1, 1), "tmo_h1");
        run(mk(1, 0, 0,      0, 0,      1,  1, 32'h71, 1, 20, 0, 1, 1), "tmo_h1out");

        // Reset clears sticky flags; long idle must never time out.
        run(mk(0, 0, 0, 0, 0, 1,  0, 32'h00, 0, 0, 0, 0, 0), "rst");
        for (int i = 0; i < 20; i++) begin
            run(mk(1, 0, 0, 0, 0, 1,  0, 32'h00, 0, 0, 0, 0, 0), $sformatf("idle%0d", i));
        end

        // Reset mid-stream after three words out, with inputs active during reset.
        run(mk(1, 1, 32'h80, 0, 0,      1,  0, 32'h00, 0, 0, 0, 0, 0), "mid_p0");
        run(mk(1, 0, 0,      1, 32'h81, 1,  1, 32'h80, 0, 1, 1, 0, 0), "mid_p1");
        run(mk(1, 1, 32'h82, 0, 0,      1,  1, 32'h81, 1, 2, 0, 0, 0), "mid_p2");
        run(mk(1, 0, 0,      1, 32'h83, 1,  1, 32'h82, 0, 3, 1, 0, 0), "mid_p3");
        run(mk(0, 1, 32'h84, 1, 32'h85, 1,  0, 32'h00, 0, 0, 0, 0, 0), "mid_rst0");
        run(mk(0, 1, 32'h86, 1, 32'h87, 1,  0, 32'h00, 0, 0, 0, 0, 0), "mid_rst1");
        run(mk(1, 0, 0,      0, 0,      1,  0, 32'h00, 0, 0, 0, 0, 0), "mid_rel");
        run(mk(1, 1, 32'h90, 0, 0,      1,  0, 32'h00, 0, 0, 0, 0, 0), "mid_q0");
        run(mk(1, 0, 0,      1, 32'h91, 1,  1, 32'h90, 0, 1, 1, 0, 0), "mid_q1");
        run(mk(1, 0, 0,      0, 0,      1,  1, 32'h91, 1, 2, 0, 0, 0), "mid_q1out");
        run(mk(1, 0, 0,      0, 0,      1,  0, 32'h91, 1, 2, 0, 0, 0), "mid_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
